tag_button_ctrl: RTL

Avalon-MM slave controller for the four DE1 push-buttons, replacing the raw input PIO on the tag Nios II system bus. Synchronizes and debounces each active-low KEY input and captures press events in a write-1-to-clear register. Keeps saturating per-button press counters and raises a maskable level interrupt to the Nios II. Software polls debounced state or services the IRQ instead of sampling bouncing raw pins.

---
 rtl/tag_button_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tag_button_ctrl.sv
// -----------------------------------------------------------------------------
// tag_button_ctrl
//
// Avalon-MM slave for the four DE1 push-buttons. Each active-low KEY input is
// synchronised, debounced, and turned into a "pressed" level. Press events
// (released -> pressed) set a write-1-to-clear EDGE bit and bump a saturating
// 8-bit counter. irq is a level interrupt that is high while any unmasked EDGE
// bit is set.
//
// Bus handshake: this slave never stalls (there is no waitrequest). A write is
// accepted at every clk edge where chipselect=1 and write_n=0. readdata is
// registered from address on every edge, regardless of chipselect, which gives
// a fixed 1-cycle read latency. Reads have no side effects.
//
// Register map (word offsets, unused bits read 0):
//   0 DATA      RO    [3:0]  debounced state, 1 = pressed
//   1 IRQ_MASK  RW    [3:0]  1 = bit enables irq
//   2 EDGE      R/W1C [3:0]  set on debounced press
//   3 DEBOUNCE  RW    [19:0] debounce period; any write clears debounce counters
//   4 PRESS_CNT RO    [31:0] {cnt3,cnt2,cnt1,cnt0}; any write zeroes all four
//   5-7         read 0, writes ignored
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous, active-low reset
//   address    [2:0] register word offset
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  [31:0] write data
//   in_port    [3:0] raw KEY inputs, asynchronous, 0 = pressed
//   readdata   [31:0] registered read data
//   irq        level interrupt
// -----------------------------------------------------------------------------
module tag_button_ctrl #(
    parameter logic [19:0] DEBOUNCE_DEFAULT = 20'd1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [3:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  stable;
    logic [19:0] cnt [4];
    logic [19:0] debounce;
    logic [19:0] d_last;
    logic [3:0]  irq_mask;
    logic [3:0]  edge_bits;
    logic [7:0]  press_cnt [4];
    logic [3:0]  accept;
    logic [3:0]  press;
    logic [31:0] rd_next;

    logic wr;
    logic wr_mask;
    logic wr_edge;
    logic wr_debounce;
    logic wr_press_cnt;

    // Upper write-data bits are never stored by any register.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:20];

    assign wr           = chipselect & ~write_n;
    assign wr_mask      = wr && (address == 3'd1);
    assign wr_edge      = wr && (address == 3'd2);
    assign wr_debounce  = wr && (address == 3'd3);
    assign wr_press_cnt = wr && (address == 3'd4);

    // A period of 0 behaves as 1, so the terminal count never underflows.
    assign d_last = (debounce == 20'd0) ? 20'd0 : (debounce - 20'd1);

    // A level change is accepted on the edge where the run of differing
    // synchronised samples reaches the debounce period.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == d_last);
        end
    end

    // Only released -> pressed acceptances are events.
    assign press = accept & sync2;

    // Inverted so that 1 = pressed from the first flop onward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~in_port;
            sync2 <= sync1;
        end
    end

    // Debounce counters. Any disagreement that goes away before acceptance
    // restarts the count, so short pulses are rejected entirely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    stable[i] <= sync2[i];
                end
                if (wr_debounce || accept[i] || (sync2[i] == stable[i])) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 20'd1;
                end
            end
        end
    end

    // Control registers. A press arriving on the same edge as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounce  <= DEBOUNCE_DEFAULT;
            irq_mask  <= '0;
            edge_bits <= '0;
        end else begin
            if (wr_debounce) begin
                debounce <= writedata[19:0];
            end
            if (wr_mask) begin
                irq_mask <= writedata[3:0];
            end
            edge_bits <= (edge_bits & ~(wr_edge ? writedata[3:0] : 4'h0)) | press;
        end
    end

    // Saturating press counters; a clear that coincides with a press leaves 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                press_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_press_cnt) begin
                    press_cnt[i] <= press[i] ? 8'd1 : 8'd0;
                end else if (press[i] && (press_cnt[i] != 8'hFF)) begin
                    press_cnt[i] <= press_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            3'd0:    rd_next = {28'd0, stable};
            3'd1:    rd_next = {28'd0, irq_mask};
            3'd2:    rd_next = {28'd0, edge_bits};
            3'd3:    rd_next = {12'd0, debounce};
            3'd4:    rd_next = {press_cnt[3], press_cnt[2], press_cnt[1], press_cnt[0]};
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edge_bits & irq_mask);

endmodule
